// File: rtl/gpu_run_seq_if.sv
// rtl/gpu_run_seq_if.sv - control, issue-handshake and status bundle for gpu_run_seq
//   master: drives go/single_step/single_go/bus_hog and stall/instr_done/pipe_busy
//   slave : drives issue_en/single_stop/halted/hog_req/step_count/drain_to
interface gpu_run_seq_if #(
    parameter int CNT_W = 16
);
    logic             go;
    logic             single_step;
    logic             single_go;
    logic             bus_hog;
    logic             stall;
    logic             instr_done;
    logic             pipe_busy;
    logic             issue_en;
    logic             single_stop;
    logic             halted;
    logic             hog_req;
    logic [CNT_W-1:0] step_count;
    logic             drain_to;

    modport master (
        output go, single_step, single_go, bus_hog, stall, instr_done, pipe_busy,
        input  issue_en, single_stop, halted, hog_req, step_count, drain_to
    );

    modport slave (
        input  go, single_step, single_go, bus_hog, stall, instr_done, pipe_busy,
        output issue_en, single_stop, halted, hog_req, step_count, drain_to
    );
endinterface

// File: rtl/gpu_run_seq.sv
// rtl/gpu_run_seq.sv - run/single-step/drain sequencer gating GPU instruction issue
//   clk, reset       : clock, synchronous active-high reset
//   bus.go/single_step/single_go/bus_hog : control-register levels and step pulse
//   bus.stall/instr_done/pipe_busy       : issue-stage and pipeline feedback
//   bus.issue_en     : combinational issue permit
//   bus.single_stop/halted/hog_req/step_count/drain_to : registered status
module gpu_run_seq #(
    parameter int CNT_W     = 16,
    parameter int DRAIN_MAX = 63
) (
    input  logic         clk,
    input  logic         reset,
    gpu_run_seq_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_PARK  = 3'd2;
    localparam logic [2:0] S_STEP  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;

    localparam int DC_W = $clog2(DRAIN_MAX + 1);

    logic [2:0]       state, state_n;
    logic             pending, pending_n;
    logic [DC_W-1:0]  drain_cnt, drain_cnt_n;
    logic [CNT_W-1:0] step_count, step_count_n;
    logic             drain_to, drain_to_n;
    logic             single_stop, halted, hog_req;
    logic             issue_en;

    // Reset gating keeps issue_en low even when state is stale during reset.
    assign issue_en = !reset && !bus.stall && (state == S_RUN || state == S_STEP);

    always_comb begin
        state_n      = state;
        pending_n    = pending;
        drain_cnt_n  = drain_cnt;
        step_count_n = step_count;
        drain_to_n   = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.go) begin
                    state_n      = bus.single_step ? S_PARK : S_RUN;
                    step_count_n = '0;
                end
            end
            S_RUN: begin
                if (!bus.go)
                    state_n = S_DRAIN;
                else if (bus.single_step)
                    state_n = S_WAIT;
            end
            S_PARK: begin
                if (!bus.go)
                    state_n = S_DRAIN;
                else if (!bus.single_step)
                    state_n = S_RUN;
                else if (bus.single_go || pending) begin
                    state_n   = S_STEP;
                    pending_n = 1'b0;
                end
            end
            S_STEP: begin
                if (bus.single_go)
                    pending_n = 1'b1;
                // An issue always completes the step, even if go drops the same cycle;
                // WAIT then routes to DRAIN.
                if (!bus.stall) begin
                    step_count_n = step_count + CNT_W'(1);
                    state_n      = S_WAIT;
                end else if (!bus.go) begin
                    state_n = S_DRAIN;
                end
            end
            S_WAIT: begin
                if (bus.single_go)
                    pending_n = 1'b1;
                if (bus.instr_done || !bus.pipe_busy) begin
                    if (!bus.go)
                        state_n = S_DRAIN;
                    else if (bus.single_step)
                        state_n = S_PARK;
                    else
                        state_n = S_RUN;
                end
            end
            S_DRAIN: begin
                if (!bus.pipe_busy) begin
                    state_n = S_IDLE;
                end else if (drain_cnt == DC_W'(DRAIN_MAX - 1)) begin
                    // This is the DRAIN_MAX-th drain cycle: give up on the pipeline.
                    state_n    = S_IDLE;
                    drain_to_n = 1'b1;
                end else begin
                    drain_cnt_n = drain_cnt + DC_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (state_n != state && (state_n == S_IDLE || state_n == S_RUN))
            pending_n = 1'b0;
        if (state_n == S_DRAIN && state != S_DRAIN)
            drain_cnt_n = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            pending     <= 1'b0;
            drain_cnt   <= '0;
            step_count  <= '0;
            drain_to    <= 1'b0;
            single_stop <= 1'b0;
            halted      <= 1'b1;
            hog_req     <= 1'b0;
        end else begin
            state       <= state_n;
            pending     <= pending_n;
            drain_cnt   <= drain_cnt_n;
            step_count  <= step_count_n;
            drain_to    <= drain_to_n;
            // Status bits follow the current state, so they lag it by one cycle.
            single_stop <= (state == S_PARK);
            halted      <= (state == S_IDLE);
            hog_req     <= bus.bus_hog && (state == S_RUN || state == S_STEP);
        end
    end

    assign bus.issue_en    = issue_en;
    assign bus.single_stop = single_stop;
    assign bus.halted      = halted;
    assign bus.hog_req     = hog_req;
    assign bus.step_count  = step_count;
    assign bus.drain_to    = drain_to;
endmodule

// File: tb/tb_gpu_run_seq.sv
// tb/tb_gpu_run_seq.sv - directed self-checking bench for gpu_run_seq
module tb_gpu_run_seq;
    logic clk;
    logic rst_a;
    logic rst_b;

    int tests;
    int fails;
    logic [15:0] exp_q[$];
    logic [15:0] model_cnt;

    gpu_run_seq_if #(.CNT_W(16)) bus_a ();
    gpu_run_seq_if #(.CNT_W(2))  bus_b ();

    gpu_run_seq #(.CNT_W(16), .DRAIN_MAX(63)) u_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a.slave)
    );

    gpu_run_seq #(.CNT_W(2), .DRAIN_MAX(4)) u_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pop(input string tag, input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed %0h expected <scoreboard empty>", tag, obs);
        end else begin
            chk(tag, obs, {16'h0, exp_q.pop_front()});
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        model_cnt = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        {bus_a.go, bus_a.single_step, bus_a.single_go, bus_a.bus_hog} = '0;
        {bus_a.stall, bus_a.instr_done, bus_a.pipe_busy} = '0;
        {bus_b.go, bus_b.single_step, bus_b.single_go, bus_b.bus_hog} = '0;
        {bus_b.stall, bus_b.instr_done, bus_b.pipe_busy} = '0;

        // ---- reset state (go already requested, must stay parked in IDLE) ----
        bus_a.go = 1'b1;
        cyc();
        cyc();
        settle();
        chk("rst_issue_en", bus_a.issue_en, 0);
        chk("rst_halted", bus_a.halted, 1);
        chk("rst_single_stop", bus_a.single_stop, 0);
        chk("rst_hog_req", bus_a.hog_req, 0);
        chk("rst_step_count", bus_a.step_count, 0);
        chk("rst_drain_to", bus_a.drain_to, 0);

        // ---- continuous run ----
        rst_a = 1'b0;
        cyc();
        chk("run_halted_edge1", bus_a.halted, 1);
        chk("run_issue_edge1", bus_a.issue_en, 1);
        cyc();
        chk("run_halted_edge2", bus_a.halted, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("run_issue", bus_a.issue_en, 1);
        end
        bus_a.bus_hog = 1'b1;
        cyc();
        chk("run_hog_req", bus_a.hog_req, 1);

        // ---- stop and drain ----
        bus_a.bus_hog = 1'b0;
        bus_a.go = 1'b0;
        bus_a.pipe_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("drain_issue", bus_a.issue_en, 0);
            chk("drain_to_quiet", bus_a.drain_to, 0);
            chk("drain_halted", bus_a.halted, 0);
        end
        chk("drain_hog_drop", bus_a.hog_req, 0);
        bus_a.pipe_busy = 1'b0;
        cyc();
        chk("drain_exit_to", bus_a.drain_to, 0);
        cyc();
        chk("drain_idle_halted", bus_a.halted, 1);

        // ---- single step ----
        bus_a.go = 1'b1;
        bus_a.single_step = 1'b1;
        bus_a.stall = 1'b1;
        bus_a.pipe_busy = 1'b1;
        cyc();
        cyc();
        chk("park_single_stop", bus_a.single_stop, 1);
        chk("park_halted", bus_a.halted, 0);
        chk("park_step_count", bus_a.step_count, 0);
        bus_a.single_go = 1'b1;
        model_cnt = 16'd1;
        exp_q.push_back(model_cnt);
        cyc();
        bus_a.single_go = 1'b0;
        settle();
        chk("step_stall_issue0", bus_a.issue_en, 0);
        cyc();
        settle();
        chk("step_stall_issue1", bus_a.issue_en, 0);
        chk("step_single_stop_low", bus_a.single_stop, 0);
        cyc();
        settle();
        chk("step_stall_issue2", bus_a.issue_en, 0);
        bus_a.stall = 1'b0;
        settle();
        chk("step_issue", bus_a.issue_en, 1);
        cyc();
        settle();
        chk("step_issue_once", bus_a.issue_en, 0);
        chk_pop("step_count_1", bus_a.step_count);
        bus_a.instr_done = 1'b1;
        cyc();
        bus_a.instr_done = 1'b0;
        cyc();
        chk("step_back_to_park", bus_a.single_stop, 1);

        // ---- pending step: RUN -> WAIT, two single_go pulses, one extra step ----
        bus_a.single_step = 1'b0;
        bus_a.stall = 1'b1;
        cyc();
        bus_a.single_step = 1'b1;
        cyc();
        bus_a.single_go = 1'b1;
        cyc();
        bus_a.single_go = 1'b0;
        cyc();
        bus_a.single_go = 1'b1;
        model_cnt = model_cnt + 16'd1;
        exp_q.push_back(model_cnt);
        cyc();
        bus_a.single_go = 1'b0;
        chk("pend_wait_no_issue", bus_a.issue_en, 0);
        chk("pend_wait_count", bus_a.step_count, 1);
        bus_a.instr_done = 1'b1;
        bus_a.stall = 1'b0;
        cyc();
        bus_a.instr_done = 1'b0;
        cyc();
        settle();
        chk("pend_step_issue", bus_a.issue_en, 1);
        cyc();
        chk_pop("pend_count_2", bus_a.step_count);
        bus_a.instr_done = 1'b1;
        cyc();
        bus_a.instr_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("pend_no_third_issue", bus_a.issue_en, 0);
            chk("pend_count_stays_2", bus_a.step_count, 2);
        end
        chk("pend_parked", bus_a.single_stop, 1);

        // ---- drain timeout on the DRAIN_MAX=4 instance ----
        rst_a = 1'b1;
        rst_b = 1'b0;
        bus_b.go = 1'b1;
        cyc();
        chk("to_run_issue", bus_b.issue_en, 1);
        bus_b.go = 1'b0;
        bus_b.pipe_busy = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("to_drain_quiet", bus_b.drain_to, 0);
            chk("to_drain_halted", bus_b.halted, 0);
        end
        cyc();
        chk("to_pulse", bus_b.drain_to, 1);
        cyc();
        chk("to_pulse_end", bus_b.drain_to, 0);
        chk("to_halted", bus_b.halted, 1);

        // ---- step counter wrap with CNT_W=2 ----
        bus_b.go = 1'b1;
        bus_b.single_step = 1'b1;
        bus_b.stall = 1'b0;
        cyc();
        model_cnt = '0;
        for (int i = 0; i < 5; i++) begin
            bus_b.single_go = 1'b1;
            model_cnt = (model_cnt + 16'd1) & 16'h3;
            exp_q.push_back(model_cnt);
            cyc();
            bus_b.single_go = 1'b0;
            cyc();
            chk_pop("wrap_step_count", {14'h0, bus_b.step_count});
            bus_b.instr_done = 1'b1;
            cyc();
            bus_b.instr_done = 1'b0;
        end

        // ---- reset asserted while stalled in STEP ----
        bus_b.stall = 1'b1;
        bus_b.single_go = 1'b1;
        cyc();
        bus_b.single_go = 1'b0;
        settle();
        chk("rstmid_stalled", bus_b.issue_en, 0);
        rst_b = 1'b1;
        bus_b.stall = 1'b0;
        settle();
        chk("rstmid_gated", bus_b.issue_en, 0);
        cyc();
        rst_b = 1'b0;
        bus_b.go = 1'b0;
        settle();
        chk("rstmid_issue", bus_b.issue_en, 0);
        chk("rstmid_halted", bus_b.halted, 1);
        chk("rstmid_count", bus_b.step_count, 0);
        chk("rstmid_single_stop", bus_b.single_stop, 0);

        chk("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gpu_run_seq.md
Name: gpu_run_seq

Overview:
- Sequences GPU instruction issue from the control-register outputs `go`, `single_step`, `single_go` and `bus_hog`.
- Decides each cycle whether the issue stage may launch an instruction.
- Drains the pipeline on stop and implements single-step handshaking.
- Drives the `single_stop` status bit read back through the status register, plus a priority request to the memory arbiter.

Parameters:
- CNT_W, 16, width of the single-step issue counter.
- DRAIN_MAX, 63, maximum cycles spent draining before a forced return; must be ≥1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous reset, active-high.
- go  in  1  level from control register; 1 = GPU running.
- single_step  in  1  level; 1 = single-step mode.
- single_go  in  1  one-cycle pulse requesting one instruction step.
- bus_hog  in  1  level; request bus priority while running.
- stall  in  1  issue stage cannot accept an issue this cycle.
- instr_done  in  1  one-cycle pulse when an issued instruction retires.
- pipe_busy  in  1  instructions still in flight.
- issue_en  out  1  permit issue this cycle (combinational from state and stall).
- single_stop  out  1  registered; GPU parked in single-step mode.
- halted  out  1  registered; 1 only in IDLE.
- hog_req  out  1  registered; bus priority request.
- step_count  out  CNT_W  registered; count of instructions issued in step mode.
- drain_to  out  1  one-cycle registered pulse when a drain hits DRAIN_MAX.

Behaviour:
- Reset values: state=IDLE, single_stop=0, halted=1, hog_req=0, step_count=0, drain_to=0, pending=0, drain counter=0.
- issue_en is 0 throughout reset.
- States: IDLE, RUN, PARK, STEP, WAIT, DRAIN.
- issue_en is 1 only when state is RUN and stall=0, or state is STEP and stall=0.
- IDLE transitions:
  - go=1, single_step=0 → RUN.
  - go=1, single_step=1 → PARK.
  - On the cycle leaving IDLE, step_count clears to 0.
- RUN transitions:
  - go=0 → DRAIN.
  - Otherwise single_step=1 → WAIT; no further issue after the transition edge.
- PARK:
  - single_stop=1, registered with 1-cycle latency from PARK entry.
  - go=0 → DRAIN.
  - Else single_step=0 → RUN.
  - Else (single_go | pending) → STEP, and pending clears.
- STEP:
  - issue_en=1 while stall=0.
  - The first cycle with stall=0 is the issue: step_count increments (wraps at 2^CNT_W−1→0), then → WAIT.
  - While stall=1, remain in STEP.
  - go=0 in STEP with no issue that cycle → DRAIN.
- WAIT:
  - No issue; wait for instr_done, or for pipe_busy=0.
  - Then → PARK if single_step=1, → RUN if single_step=0 and go=1, → DRAIN if go=0.
  - instr_done and go=0 in the same cycle → DRAIN.
- DRAIN:
  - No issue; the drain counter increments each cycle.
  - pipe_busy=0 → IDLE.
  - If the counter reaches DRAIN_MAX with pipe_busy still 1 → IDLE, and drain_to pulses for 1 cycle.
  - The counter clears on DRAIN entry.
- single_go handling:
  - A pulse in STEP or WAIT sets pending; at most one pending step (further pulses are ignored).
  - A pulse in IDLE, RUN or DRAIN is ignored and does not set pending.
  - pending clears on entry to IDLE or RUN.
- single_stop=1 only while state is PARK (registered, 1-cycle lag); 0 in all other states.
- halted=1 only while state is IDLE (registered, 1-cycle lag).
- hog_req = registered (bus_hog & state∈{RUN, STEP}); drops to 0 one cycle after leaving these states.
- Simultaneous single_step 0→1 and go 1→0 in RUN: go takes priority → DRAIN.
- Reset asserted mid-operation: all state returns to reset values on that edge regardless of stall, pipe_busy or pending.

Test Plan:
- Continuous run:
  - Reset, then go=1, single_step=0, stall=0 → halted falls after 2 edges; issue_en=1 every cycle.
  - Set bus_hog=1 → hog_req=1 one cycle later.
- Stop and drain:
  - In RUN, go=0 with pipe_busy=1 for 5 cycles → issue_en=0 immediately; IDLE after pipe_busy falls.
  - halted=1 next cycle; drain_to stays 0.
- Single step:
  - go=1, single_step=1 → single_stop=1.
  - Pulse single_go with stall=1 for 3 cycles → issue_en held 0 for 3 cycles, then exactly 1 cycle at 1.
  - step_count=1; after instr_done, single_stop returns to 1.
- Pending step:
  - Pulse single_go twice while in WAIT → exactly one extra step issued.
  - step_count goes from 1 to 2, never 3.
- Drain timeout:
  - DRAIN_MAX=4, go=0 in RUN, pipe_busy held 1 → IDLE after 4 cycles.
  - drain_to pulses once; halted=1.
- Wrap and reset:
  - CNT_W=2, take 5 single steps → step_count sequence 1,2,3,0,1.
  - Assert reset during STEP with stall=1 → next cycle issue_en=0, halted=1, step_count=0.
